// File: rtl/key_event_array.sv
// key_event_array: per-key synchroniser, debouncer and press/release/long/repeat
// event generator. Every channel has its own counters and state machine.
module key_event_array #(
  parameter int unsigned N_KEYS        = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_in,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  localparam int unsigned DB_W   = $clog2(STABLE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  // Pin level that means "not pressed"; synchronisers reset to it.
  localparam logic IDLE_LVL = ACTIVE_LOW;

  typedef enum logic [2:0] {
    S_RELEASED,
    S_PRESS_PEND,
    S_PRESSED,
    S_LONG,
    S_RELEASE_PEND
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pressed;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= {N_KEYS{IDLE_LVL}};
      sync2 <= {N_KEYS{IDLE_LVL}};
    end else begin
      sync1 <= i_in;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ {N_KEYS{IDLE_LVL}};

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    state_t            state, state_nx;
    logic              from_long, from_long_nx;
    logic [DB_W-1:0]   db_cnt, db_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic [REP_W-1:0]  rep_cnt, rep_cnt_nx;
    logic              level_q, level_nx;
    logic              press_q, press_nx;
    logic              release_q, release_nx;
    logic              long_q, long_nx;
    logic              repeat_q, repeat_nx;

    // State, counters and registered event outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state     <= S_RELEASED;
        from_long <= 1'b0;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state     <= state_nx;
        from_long <= from_long_nx;
        db_cnt    <= db_cnt_nx;
        hold_cnt  <= hold_cnt_nx;
        rep_cnt   <= rep_cnt_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
        repeat_q  <= repeat_nx;
      end
    end

    // Debounce / hold / repeat state machine; a release bounce returns to
    // the state it came from with hold and repeat counts untouched.
    always_comb begin
      state_nx     = state;
      from_long_nx = from_long;
      db_cnt_nx    = db_cnt;
      hold_cnt_nx  = hold_cnt;
      rep_cnt_nx   = rep_cnt;
      level_nx     = level_q;
      press_nx     = 1'b0;
      release_nx   = 1'b0;
      long_nx      = 1'b0;
      repeat_nx    = 1'b0;
      unique case (state)
        S_RELEASED: begin
          if (pressed[k]) begin
            state_nx  = S_PRESS_PEND;
            db_cnt_nx = '0;
          end
        end
        S_PRESS_PEND: begin
          if (!pressed[k]) begin
            state_nx  = S_RELEASED;
            db_cnt_nx = '0;
          end else if (db_cnt == DB_LAST) begin
            state_nx    = S_PRESSED;
            db_cnt_nx   = '0;
            hold_cnt_nx = '0;
            level_nx    = 1'b1;
            press_nx    = 1'b1;
          end else begin
            db_cnt_nx = db_cnt + DB_W'(1);
          end
        end
        S_PRESSED: begin
          if (!pressed[k]) begin
            state_nx     = S_RELEASE_PEND;
            from_long_nx = 1'b0;
            db_cnt_nx    = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nx   = S_LONG;
            rep_cnt_nx = '0;
            long_nx    = 1'b1;
          end else begin
            hold_cnt_nx = hold_cnt + HOLD_W'(1);
          end
        end
        S_LONG: begin
          if (!pressed[k]) begin
            state_nx     = S_RELEASE_PEND;
            from_long_nx = 1'b1;
            db_cnt_nx    = '0;
          end else if (!i_repeat_en[k]) begin
            rep_cnt_nx = '0;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt_nx = '0;
            repeat_nx  = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + REP_W'(1);
          end
        end
        S_RELEASE_PEND: begin
          if (pressed[k]) begin
            state_nx  = from_long ? S_LONG : S_PRESSED;
            db_cnt_nx = '0;
          end else if (db_cnt == DB_LAST) begin
            state_nx   = S_RELEASED;
            db_cnt_nx  = '0;
            level_nx   = 1'b0;
            release_nx = 1'b1;
          end else begin
            db_cnt_nx = db_cnt + DB_W'(1);
          end
        end
        default: begin
          state_nx = S_RELEASED;
        end
      endcase
    end

    assign o_level[k]   = level_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_long[k]    = long_q;
    assign o_repeat[k]  = repeat_q;
  end

endmodule

// File: tb/tb_key_event_array.sv
// Scoreboard bench for key_event_array: each scenario pushes the expected
// pulse events (cycle + per-output masks) and compares them with the events
// the monitor captured from the DUT.
module tb_key_event_array;

  localparam int unsigned NK = 3;

  typedef struct packed {
    int unsigned   cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rls;
    logic [NK-1:0] lng;
    logic [NK-1:0] rpt;
  } ev_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [NK-1:0] pins   = '1;
  logic [NK-1:0] rep_en = '0;
  logic [NK-1:0] level, press, rls, lng, rpt;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  key_event_array #(
    .N_KEYS(NK),
    .ACTIVE_LOW(1'b1),
    .STABLE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(6)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_in(pins),
    .i_repeat_en(rep_en),
    .o_level(level),
    .o_press(press),
    .o_release(rls),
    .o_long(lng),
    .o_repeat(rpt)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int unsigned c, input logic [NK-1:0] p,
                             input logic [NK-1:0] r, input logic [NK-1:0] l,
                             input logic [NK-1:0] t);
    ev_t e;
    e.cyc = c; e.press = p; e.rls = r; e.lng = l; e.rpt = t;
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d press=%b release=%b long=%b repeat=%b",
                     e.cyc, e.press, e.rls, e.lng, e.rpt);
  endfunction

  // Monitor: capture every cycle with any pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if ((press | rls | lng | rpt) != '0)
      obs_q.push_back(mk(cyc, press, rls, lng, rpt));
  end

  task automatic goto(input int unsigned t);
    do @(negedge clk); while (cyc < t);
    #1;
  endtask

  task automatic begin_test(output int unsigned c);
    @(negedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    c = cyc;
  endtask

  task automatic test_reset();
    int unsigned c;
    rst_n = 1'b0; pins = '1; rep_en = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({level, press, rls, lng, rpt} !== '0) begin
      n_fail++;
      $display("FAIL reset_asserted: outputs=%b expected all 0", {level, press, rls, lng, rpt});
    end
    #1 rst_n = 1'b1;
    begin_test(c);
    goto(c + 8);
    n_checks++;
    if ({level, press, rls, lng, rpt} !== '0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%b events=%0d expected 0/0",
               {level, press, rls, lng, rpt}, obs_q.size());
    end
  endtask

  task automatic test_press();
    int unsigned c;
    begin_test(c);
    pins[0] = 1'b0;
    exp_q.push_back(mk(c + 7, 3'b001, 3'b000, 3'b000, 3'b000));
    goto(c + 6);
    n_checks++;
    if (level !== 3'b000) begin
      n_fail++; $display("FAIL press_level_before: got %b expected 000", level);
    end
    goto(c + 7);
    n_checks++;
    if (level !== 3'b001) begin
      n_fail++; $display("FAIL press_level_after: got %b expected 001", level);
    end
    goto(c + 12);
    pins[0] = 1'b1;
    exp_q.push_back(mk(c + 19, 3'b000, 3'b001, 3'b000, 3'b000));
    goto(c + 30);
    n_checks++;
    if (level !== 3'b000) begin
      n_fail++; $display("FAIL press_level_released: got %b expected 000", level);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL press_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL press_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned c;
    begin_test(c);
    pins[1] = 1'b0;
    goto(c + 3);
    pins[1] = 1'b1;
    goto(c + 20);
    n_checks++;
    if (level !== 3'b000 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_press: level=%b events=%0d expected 000/0", level, obs_q.size());
    end
    begin_test(c);
    pins[1] = 1'b0;
    exp_q.push_back(mk(c + 7, 3'b010, 3'b000, 3'b000, 3'b000));
    goto(c + 10);
    pins[1] = 1'b1;
    goto(c + 13);
    pins[1] = 1'b0;
    goto(c + 20);
    n_checks++;
    if (level !== 3'b010) begin
      n_fail++; $display("FAIL glitch_release_level: got %b expected 010", level);
    end
    pins[1] = 1'b1;
    exp_q.push_back(mk(c + 27, 3'b000, 3'b010, 3'b000, 3'b000));
    goto(c + 40);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL glitch_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL glitch_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_long_repeat();
    int unsigned c;
    begin_test(c);
    rep_en[2] = 1'b1;
    pins[2] = 1'b0;
    exp_q.push_back(mk(c + 7,  3'b100, 3'b000, 3'b000, 3'b000));
    exp_q.push_back(mk(c + 27, 3'b000, 3'b000, 3'b100, 3'b000));
    exp_q.push_back(mk(c + 33, 3'b000, 3'b000, 3'b000, 3'b100));
    exp_q.push_back(mk(c + 39, 3'b000, 3'b000, 3'b000, 3'b100));
    exp_q.push_back(mk(c + 45, 3'b000, 3'b000, 3'b000, 3'b100));
    goto(c + 46);
    pins[2] = 1'b1;
    exp_q.push_back(mk(c + 53, 3'b000, 3'b100, 3'b000, 3'b000));
    goto(c + 75);
    rep_en[2] = 1'b0;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL long_repeat_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL long_repeat_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_repeat_enable();
    int unsigned c;
    begin_test(c);
    rep_en[2] = 1'b0;
    pins[2] = 1'b0;
    exp_q.push_back(mk(c + 7,  3'b100, 3'b000, 3'b000, 3'b000));
    exp_q.push_back(mk(c + 27, 3'b000, 3'b000, 3'b100, 3'b000));
    goto(c + 40);
    rep_en[2] = 1'b1;
    exp_q.push_back(mk(c + 46, 3'b000, 3'b000, 3'b000, 3'b100));
    exp_q.push_back(mk(c + 52, 3'b000, 3'b000, 3'b000, 3'b100));
    goto(c + 54);
    pins[2] = 1'b1;
    exp_q.push_back(mk(c + 61, 3'b000, 3'b100, 3'b000, 3'b000));
    goto(c + 75);
    rep_en[2] = 1'b0;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL repeat_enable_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL repeat_enable_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_simultaneous();
    int unsigned c;
    begin_test(c);
    pins[1:0] = 2'b00;
    exp_q.push_back(mk(c + 7, 3'b011, 3'b000, 3'b000, 3'b000));
    goto(c + 10);
    n_checks++;
    if (level !== 3'b011) begin
      n_fail++; $display("FAIL simultaneous_level: got %b expected 011", level);
    end
    pins[0] = 1'b1;
    exp_q.push_back(mk(c + 17, 3'b000, 3'b001, 3'b000, 3'b000));
    goto(c + 12);
    pins[1] = 1'b1;
    exp_q.push_back(mk(c + 19, 3'b000, 3'b010, 3'b000, 3'b000));
    goto(c + 30);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL simultaneous_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL simultaneous_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned c;
    int unsigned r;
    begin_test(c);
    pins[0] = 1'b0;
    exp_q.push_back(mk(c + 7,  3'b001, 3'b000, 3'b000, 3'b000));
    exp_q.push_back(mk(c + 27, 3'b000, 3'b000, 3'b001, 3'b000));
    goto(c + 30);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, press, rls, lng, rpt} !== '0) begin
      n_fail++; $display("FAIL reset_mid_hold_async: outputs=%b expected all 0", {level, press, rls, lng, rpt});
    end
    goto(c + 33);
    rst_n = 1'b1;
    r = cyc;
    exp_q.push_back(mk(r + 7,  3'b001, 3'b000, 3'b000, 3'b000));
    exp_q.push_back(mk(r + 27, 3'b000, 3'b000, 3'b001, 3'b000));
    goto(r + 35);
    pins[0] = 1'b1;
    exp_q.push_back(mk(r + 42, 3'b000, 3'b001, 3'b000, 3'b000));
    goto(r + 50);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL reset_mid_hold_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_mid_hold_event%0d: got %s expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long_repeat();
    test_repeat_enable();
    test_simultaneous();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/key_event_array.md
Name: key_event_array

Overview:
- Parametrised multi-key front end that replaces per-key single-output debouncers in board-level top files.
- For each of N_KEYS push-buttons it synchronises, debounces and generates:
  - press and release pulses
  - a long-press pulse
  - optional auto-repeat pulses
- Sits between board KEY/SW pins and the design core, in the audio-codec clock domain (12 MHz).

Parameters:
- N_KEYS, 4, number of independent key channels.
- ACTIVE_LOW, 1, 1: pin low means pressed; 0: pin high means pressed.
- STABLE_CYCLES, 240000, consecutive cycles a new synchronised level must hold before acceptance (20 ms at 12 MHz); must be >= 2.
- LONG_CYCLES, 12000000, cycles a key must stay debounced-pressed before o_long fires (1 s); must be >= 2.
- REPEAT_CYCLES, 2400000, auto-repeat period after o_long (200 ms); must be >= 2.

Ports:
- i_clk  input  1  system clock (12 MHz audio clock).
- i_rst_n  input  1  asynchronous active-low reset.
- i_in  input  N_KEYS  raw key pins, asynchronous to i_clk.
- i_repeat_en  input  N_KEYS  per-key auto-repeat enable, synchronous.
- o_level  output  N_KEYS  debounced logical state, 1 = pressed.
- o_press  output  N_KEYS  1-cycle pulse on accepted press.
- o_release  output  N_KEYS  1-cycle pulse on accepted release.
- o_long  output  N_KEYS  1-cycle pulse when hold time reaches LONG_CYCLES.
- o_repeat  output  N_KEYS  1-cycle auto-repeat pulses.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst_n. All flops clear on reset assertion.
- Reset values:
  - All outputs 0.
  - Synchroniser flops at the released pin level (1 when ACTIVE_LOW=1).
  - All counters 0; every channel in RELEASED.
- Channels are fully independent; there are no shared counters.
- Each i_in bit passes through a 2-flop synchroniser, then is converted to a logical level p (1 = pressed, according to ACTIVE_LOW).
- Per-channel FSM: RELEASED, PRESS_PEND, PRESSED, LONG, RELEASE_PEND.
  - RELEASED: p=1 -> PRESS_PEND, debounce counter cleared to 0.
  - PRESS_PEND:
    - Counter increments each cycle p=1.
    - p=0 -> RELEASED, counter cleared, no pulse.
    - When the counter reaches STABLE_CYCLES-1 with p=1 -> PRESSED. o_level rises and o_press pulses in the same cycle. Hold counter cleared to 0.
  - PRESSED:
    - Hold counter increments each cycle.
    - When the hold counter reaches LONG_CYCLES-1 -> LONG, o_long pulses, repeat counter cleared.
    - p=0 -> RELEASE_PEND.
  - LONG:
    - If i_repeat_en[k]=1, the repeat counter increments. At REPEAT_CYCLES-1, o_repeat pulses and the counter wraps to 0.
    - If i_repeat_en[k]=0, the repeat counter holds at 0 and no o_repeat is generated. Enable may toggle at any time and takes effect the next cycle.
    - p=0 -> RELEASE_PEND.
  - RELEASE_PEND:
    - Debounce counter counts cycles with p=0.
    - Hold and repeat counters are frozen; o_long and o_repeat are suppressed.
    - p=1 -> return to the originating state (PRESSED or LONG), counter cleared.
    - When the counter reaches STABLE_CYCLES-1 with p=0 -> RELEASED. o_level falls and o_release pulses.
- Latency: a clean pin edge is sampled at edge E. The corresponding o_level change / o_press or o_release pulse appears STABLE_CYCLES+2 edges after E (2 synchroniser stages plus debounce).
- o_press and o_release never assert in the same cycle on the same channel. o_long and o_repeat never assert in the same cycle.
- Simultaneous events on different channels are each reported in their own bit in the same cycle.
- Counter widths:
  - Debounce counter: $clog2(STABLE_CYCLES).
  - Hold counter: $clog2(LONG_CYCLES). It stops counting once in LONG.
  - Repeat counter: $clog2(REPEAT_CYCLES).
- Key held down through reset deassertion: treated as a fresh press; o_press fires after the normal debounce.
- Reset asserted mid-hold: all pulses stop immediately; no o_release is generated.

Test Plan:
Common setup: N_KEYS=3, ACTIVE_LOW=1, STABLE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=6.
1. Reset, pins all 1 -> all outputs 0. Drive i_in[0]=0 at edge 10 -> o_press[0] one cycle at edge 16, o_level[0]=1 from edge 16.
2. Glitch i_in[1] low for 3 cycles, then high -> no o_press[1]; o_level[1] stays 0. Repeat with the glitch on release of a held key -> no o_release.
3. Hold key 2 with i_repeat_en[2]=1 -> o_long[2] at 20 cycles after o_press[2]; o_repeat[2] at +6, +12, +18 after o_long. Release -> o_release 6 edges after the pin edge, no further pulses.
4. Same as 3 with i_repeat_en[2]=0 -> o_long only, no o_repeat. Set the enable mid-LONG -> first o_repeat 6 cycles later.
5. Press keys 0 and 1 on the same edge -> o_press=3'b011 in a single cycle. Release key 0 only -> o_release=3'b001.
6. Assert i_rst_n low while key 0 is in LONG -> all outputs 0 asynchronously. Deassert with pin still low -> o_press[0] 6 edges later, with a fresh long-press count.
